// File: rtl/canvas_pkg.sv
// Shared types and constants for the canvas pixel path and its UART dump reader.
package canvas_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync0,
    StSync1,
    StRead,
    StCapture,
    StSendHi,
    StSendLo,
    StFinish
  } dump_state_e;

  typedef logic [11:0] colour_t;

  localparam logic [7:0] Sync0 = 8'hA5;
  localparam logic [7:0] Sync1 = 8'h5A;

  localparam int unsigned DefaultHPixels = 640;
  localparam int unsigned DefaultVPixels = 480;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 transmitter for one byte; line idles high whenever no byte is in flight.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       pixel_clk_25,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      frame_q, frame_d;
  logic            busy_q, busy_d;

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (tx_start) begin
        busy_d  = 1'b1;
        frame_d = {1'b1, tx_data, 1'b0};
        baud_d  = '0;
        bit_d   = '0;
      end
    end else if (baud_q == CntW'(CLKS_PER_BIT - 1)) begin
      // Baud counter restarts on every bit boundary so no error accumulates.
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
      end else begin
        bit_d   = bit_q + 4'd1;
        frame_d = {1'b1, frame_q[9:1]};
      end
    end else begin
      baud_d = baud_q + CntW'(1);
    end
  end

  always_ff @(posedge pixel_clk_25) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_busy = busy_q;
  assign uart_tx = busy_q ? frame_q[0] : 1'b1;

endmodule

// File: rtl/canvas_uart_dump.sv
// Streams the canvas out of pixel memory in raster order over UART: A5 5A, then
// {4'h0,R},{G,B} per pixel.
module canvas_uart_dump
  import canvas_pkg::*;
#(
  parameter int unsigned H_PIXELS     = DefaultHPixels,
  parameter int unsigned V_PIXELS     = DefaultVPixels,
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        pixel_clk_25,
  input  logic        reset,
  input  logic        start,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y,
  input  logic [11:0] rd_colour,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  dump_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  colour_t     colour_q, colour_d;
  logic        tx_start, tx_busy;
  logic [7:0]  tx_data;
  logic        last_col, last_row;

  assign last_col = (x_q == 10'(H_PIXELS - 1));
  assign last_row = (y_q == 10'(V_PIXELS - 1));

  always_ff @(posedge pixel_clk_25) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSync0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StSync0:   if (!tx_busy) state_d = StSync1;
      StSync1:   if (!tx_busy) state_d = StRead;
      StRead:    state_d = StCapture;
      StCapture: begin
        colour_d = rd_colour;
        state_d  = StSendHi;
      end
      StSendHi:  if (!tx_busy) state_d = StSendLo;
      StSendLo: begin
        if (!tx_busy) begin
          state_d = StRead;
          if (!last_col) begin
            x_d = x_q + 10'd1;
          end else begin
            x_d = '0;
            if (last_row) begin
              y_d     = '0;
              state_d = StFinish;
            end else begin
              y_d = y_q + 10'd1;
            end
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Each byte is launched on the cycle the previous one finishes, keeping gaps short.
  always_comb begin
    tx_start = 1'b0;
    tx_data  = Sync0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy     = 1'b0;
        tx_start = start;
        tx_data  = Sync0;
      end
      StSync0: begin
        tx_start = !tx_busy;
        tx_data  = Sync1;
      end
      StCapture: begin
        // Same value that lands in colour_q on this edge.
        tx_start = !tx_busy;
        tx_data  = {4'h0, rd_colour[11:8]};
      end
      StSendHi: begin
        tx_start = !tx_busy;
        tx_data  = colour_q[7:0];
      end
      StFinish: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_x = x_q;
  assign rd_y = y_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .pixel_clk_25(pixel_clk_25),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .uart_tx     (uart_tx)
  );

endmodule

// File: tb/tb_canvas_uart_dump.sv
// Bench for canvas_uart_dump on a 4x2 canvas at 4 clocks per bit, with a decoding UART monitor.
module tb_canvas_uart_dump;

  localparam int unsigned H    = 4;
  localparam int unsigned V    = 2;
  localparam int unsigned Clks = 4;
  localparam int          Bound = 4000;

  logic        pixel_clk_25 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  rd_x, rd_y;
  logic [11:0] rd_colour;
  logic        uart_tx, busy, done;

  always #5 pixel_clk_25 = ~pixel_clk_25;

  canvas_uart_dump #(
    .H_PIXELS    (H),
    .V_PIXELS    (V),
    .CLKS_PER_BIT(Clks)
  ) dut (
    .pixel_clk_25(pixel_clk_25),
    .reset       (reset),
    .start       (start),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_colour   (rd_colour),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .done        (done)
  );

  // Pixel memory with one cycle of read latency.
  logic [11:0] mem [V][H];
  always @(posedge pixel_clk_25) rd_colour <= mem[rd_y[0]][rd_x[1:0]];

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int byte_starts = 0;
  int bytes_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Serial decoder: samples on the falling edge, checks bit widths and inter-byte gaps.
  initial begin
    bit         active = 1'b0;
    bit         first_byte = 1'b1;
    int         samp = 0;
    int         bitn = 0;
    int         bad = 0;
    int         gap = 0;
    logic       lvl = 1'b1;
    logic [7:0] shreg = '0;
    forever begin
      @(negedge pixel_clk_25);
      if (done === 1'b1) done_cnt++;
      if (reset) begin
        active = 1'b0;
        first_byte = 1'b1;
        gap = 0;
      end else if (!active) begin
        if (uart_tx === 1'b0) begin
          if (!first_byte) check_eq("gap_le3", gap <= 3, 1);
          first_byte = 1'b0;
          active = 1'b1;
          samp = 1;
          bitn = 0;
          bad = 0;
          lvl = 1'b0;
          byte_starts++;
        end else begin
          gap++;
        end
        if (done === 1'b1) first_byte = 1'b1;
      end else begin
        if (samp == 0) begin
          lvl = uart_tx;
          if (bitn >= 1 && bitn <= 8) shreg[bitn-1] = uart_tx;
          if (bitn == 9 && uart_tx !== 1'b1) bad++;
        end else if (uart_tx !== lvl) begin
          bad++;
        end
        samp++;
        if (samp == Clks) begin
          samp = 0;
          if (bitn == 9) begin
            active = 1'b0;
            gap = 0;
            bytes_seen++;
            check_eq("bit_timing", bad, 0);
            check_eq("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("byte", {24'b0, shreg}, {24'b0, exp_q.pop_front()});
          end else begin
            bitn++;
          end
        end
      end
    end
  end

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        exp_q.push_back({4'h0, 4'(x)});
        exp_q.push_back({4'(y), 4'hC});
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge pixel_clk_25);
    #1 start = 1'b1;
    @(posedge pixel_clk_25);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < Bound && done !== 1'b1; i++) @(negedge pixel_clk_25);
    check_eq(tag, done, 1);
    check_eq({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic check_idle_after(input string tag, input int exp_done);
    repeat (20) @(negedge pixel_clk_25);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    check_eq({tag, "_done_cnt"}, done_cnt, exp_done);
    check_eq({tag, "_line_idle"}, uart_tx, 1);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base;
    int dsave;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) mem[y][x] = {4'(x), 4'(y), 4'hC};

    repeat (3) @(posedge pixel_clk_25);
    @(negedge pixel_clk_25);
    check_eq("rst_uart_tx", uart_tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_x", rd_x, 0);
    check_eq("rst_rd_y", rd_y, 0);
    @(posedge pixel_clk_25);
    #1 reset = 1'b0;
    repeat (5) @(negedge pixel_clk_25);
    check_eq("idle_line_high", uart_tx, 1);

    // Plain frame.
    push_frame();
    pulse_start();
    @(negedge pixel_clk_25);
    check_eq("busy_after_start", busy, 1);
    wait_done("done1");
    check_idle_after("f1", 1);

    // Extra starts mid-frame and on the done cycle must be ignored.
    push_frame();
    base = bytes_seen;
    pulse_start();
    for (int i = 0; i < Bound && bytes_seen < base + 5; i++) @(negedge pixel_clk_25);
    check_eq("reach_byte5", bytes_seen >= base + 5, 1);
    pulse_start();
    wait_done("done2");
    start = 1'b1;
    @(posedge pixel_clk_25);
    #1 start = 1'b0;
    repeat (100) @(negedge pixel_clk_25);
    check_idle_after("f2", 2);

    // Memory for pixel (1,0) changes while its high byte is on the wire.
    push_frame();
    base = byte_starts;
    pulse_start();
    for (int i = 0; i < Bound && byte_starts < base + 5; i++) @(negedge pixel_clk_25);
    check_eq("reach_px1_hi", byte_starts >= base + 5, 1);
    mem[0][1] = 12'hFFF;
    wait_done("done3");
    mem[0][1] = {4'd1, 4'd0, 4'hC};
    check_idle_after("f3", 3);

    // Reset in the middle of pixel (2,1)'s high byte.
    push_frame();
    base = byte_starts;
    pulse_start();
    for (int i = 0; i < Bound && byte_starts < base + 15; i++) @(negedge pixel_clk_25);
    check_eq("reach_px6_hi", byte_starts >= base + 15, 1);
    check_eq("px6_rd_x", rd_x, 2);
    check_eq("px6_rd_y", rd_y, 1);
    repeat (2 * Clks) @(negedge pixel_clk_25);
    dsave = done_cnt;
    @(posedge pixel_clk_25);
    #1 reset = 1'b1;
    @(posedge pixel_clk_25);
    @(negedge pixel_clk_25);
    check_eq("abort_uart_tx", uart_tx, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rd_x", rd_x, 0);
    check_eq("abort_rd_y", rd_y, 0);
    check_eq("abort_done", done, 0);
    exp_q.delete();
    @(posedge pixel_clk_25);
    #1 reset = 1'b0;
    repeat (50) @(negedge pixel_clk_25);
    check_eq("abort_no_done", done_cnt, dsave);

    // Full frame after the abort.
    push_frame();
    pulse_start();
    wait_done("done5");
    check_idle_after("f5", dsave + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
